hier_tap_chain: RTL and testbench

Parametrised two-chain register pipeline with a runtime-selectable hierarchical tap.
- Chain A delays the input by DEPTH stages to O0.
- Chain B is fed from a selected intermediate stage of chain A and delays it by DEPTH more stages to O1.
- Sits between front-end sample sources and downstream consumers that need both a full-latency copy and a variable-latency copy of the same stream, with per-stage valid tracking and a global stall.

---
 rtl/hier_tap_pkg.sv | 12 +
 rtl/tap_chain.sv | 56 +++++
 rtl/hier_tap_chain.sv | 99 +++++++++
 tb/tb_hier_tap_chain.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hier_tap_pkg.sv
// Shared definitions for hier_tap_chain: default geometry and the tap clamp.
package hier_tap_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Out-of-range tap requests select the last legal stage rather than wrapping.
    function automatic int unsigned clamp_tap(input int unsigned sel, input int unsigned depth);
        return (sel >= depth) ? depth - 1 : sel;
    endfunction

endpackage

// File: rtl/tap_chain.sv
// One DEPTH-stage data+valid shift chain with clock enable, synchronous
// active-high reset and a valid-only flush. Every stage is exposed so the
// parent can tap any of them. Stage k of the chain is index k-1 of stage_data.
module tap_chain
    import hier_tap_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic [DEPTH-1:0][WIDTH-1:0]  stage_data,
    output logic [DEPTH-1:0]             stage_valid
);

    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            valid_q, valid_d;

    // Next-state: shift on enable; a flush kills every valid bit (including
    // the incoming one) and leaves the data untouched.
    always_comb begin
        // NOTE: defaulting every output to its held value first keeps this
        // block purely combinational; a missing default would infer a latch.
        data_d  = data_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else if (ce) begin
            data_d  = {data_q[DEPTH-2:0], in_data};
            valid_d = {valid_q[DEPTH-2:0], in_valid};
        end
    end

    // State update with synchronous reset taking priority over enable and flush.
    always_ff @(posedge clk) begin
        // NOTE: these are individual pipeline flops, not a RAM, so clearing the
        // data alongside the valids is cheap and gives deterministic outputs.
        if (reset) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the value
            // its neighbour held before this edge, independent of statement order.
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign stage_data  = data_q;
    assign stage_valid = valid_q;

endmodule

// File: rtl/hier_tap_chain.sv
// Two-chain register pipeline with a runtime-selectable tap.
// Chain A delays I by DEPTH stages to O0; chain B is fed from chain-A stage
// tap_q+1 and delays it by DEPTH more stages to O1.
// Optional feature: define TAP_CHAIN_FLUSH_EN to add the FLUSH port, which
// clears every valid bit in both chains while data and tap_q hold.
module hier_tap_chain
    import hier_tap_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
`ifdef TAP_CHAIN_FLUSH_EN
    input  logic             FLUSH,
`endif
    input  logic [WIDTH-1:0] I,
    input  logic             I_valid,
    input  logic [SEL_W-1:0] tap_sel,
    output logic [WIDTH-1:0] O0,
    output logic             O0_valid,
    output logic [WIDTH-1:0] O1,
    output logic             O1_valid
);

    localparam int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                        flush;
    logic [TAP_W-1:0]            tap_q, tap_d;
    logic [DEPTH-1:0][WIDTH-1:0] a_data, b_data;
    logic [DEPTH-1:0]            a_valid, b_valid;
    logic [WIDTH-1:0]            b_in_data;
    logic                        b_in_valid;

`ifdef TAP_CHAIN_FLUSH_EN
    assign flush = FLUSH;
`else
    assign flush = 1'b0;
`endif

    // Tap select: registered and clamped; frozen while stalled or flushing.
    always_comb begin
        tap_d = tap_q;
        if (!flush && CE) begin
            tap_d = TAP_W'(clamp_tap(32'(tap_sel), DEPTH));
        end
    end

    // Tap register with synchronous reset to stage 1.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tap_q <= '0;
        end else begin
            tap_q <= tap_d;
        end
    end

    // Tap mux: chain B input comes from chain-A stage tap_q+1, data and valid together.
    always_comb begin
        b_in_data  = a_data[tap_q];
        b_in_valid = a_valid[tap_q];
    end

    tap_chain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_chain_a (
        .clk         (CLK),
        .reset       (RESET),
        .ce          (CE),
        .flush       (flush),
        .in_data     (I),
        .in_valid    (I_valid),
        .stage_data  (a_data),
        .stage_valid (a_valid)
    );

    tap_chain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_chain_b (
        .clk         (CLK),
        .reset       (RESET),
        .ce          (CE),
        .flush       (flush),
        .in_data     (b_in_data),
        .in_valid    (b_in_valid),
        .stage_data  (b_data),
        .stage_valid (b_valid)
    );

    assign O0       = a_data[DEPTH-1];
    assign O0_valid = a_valid[DEPTH-1];
    assign O1       = b_data[DEPTH-1];
    assign O1_valid = b_valid[DEPTH-1];

endmodule

// File: tb/tb_hier_tap_chain.sv
// Scoreboard bench for hier_tap_chain (WIDTH=8, DEPTH=4, SEL_W=3 so that an
// out-of-range tap_sel can be driven). The driver pushes each expected output
// sample with the clock-enabled edge index at which it must appear; the
// monitor pops and compares whenever O0_valid / O1_valid is presented.
// Builds with or without TAP_CHAIN_FLUSH_EN.
module tb_hier_tap_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SEL_W = 3;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               idx;
    } exp_t;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             CE;
`ifdef TAP_CHAIN_FLUSH_EN
    logic             FLUSH;
`endif
    logic [WIDTH-1:0] I;
    logic             I_valid;
    logic [SEL_W-1:0] tap_sel;
    logic [WIDTH-1:0] O0;
    logic             O0_valid;
    logic [WIDTH-1:0] O1;
    logic             O1_valid;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ce_n     = 0;     // number of clock-enabled, non-reset edges so far
    logic ce_edge = 1'b0; // last edge shifted the chains

    hier_tap_chain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .CE       (CE),
`ifdef TAP_CHAIN_FLUSH_EN
        .FLUSH    (FLUSH),
`endif
        .I        (I),
        .I_valid  (I_valid),
        .tap_sel  (tap_sel),
        .O0       (O0),
        .O0_valid (O0_valid),
        .O1       (O1),
        .O1_valid (O1_valid)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Edge bookkeeping for the scoreboard timing checks.
    always @(posedge CLK) begin
        ce_edge <= CE && !RESET;
        if (CE && !RESET) ce_n <= ce_n + 1;
    end

    // Monitor: compare presented outputs against the scoreboard queues.
    always @(negedge CLK) begin
        exp_t e;
        if (ce_edge) begin
            if (O0_valid) begin
                if (q0.size() == 0) begin
                    check("o0_unexpected_valid", int'(O0_valid), 0);
                end else begin
                    e = q0.pop_front();
                    check("o0_data", int'(O0), int'(e.data));
                    check("o0_edge", ce_n, e.idx);
                end
            end
            if (O1_valid) begin
                if (q1.size() == 0) begin
                    check("o1_unexpected_valid", int'(O1_valid), 0);
                end else begin
                    e = q1.pop_front();
                    check("o1_data", int'(O1), int'(e.data));
                    check("o1_edge", ce_n, e.idx);
                end
            end
        end
    end

    // One clock of stimulus. When the sample is accepted (CE high, valid) and
    // do_push is set, O0 must show it DEPTH-1 enabled edges after acceptance;
    // if o1_lat >= 0, O1 must show it o1_lat enabled edges after acceptance.
    task automatic drive(input logic [WIDTH-1:0] d, input logic v, input logic ce,
                         input logic do_push, input int o1_lat);
        int m;
        m = ce_n + 1;
        if (ce && v && do_push && !RESET) begin
            q0.push_back('{data: d, idx: m + DEPTH - 1});
            if (o1_lat >= 0) q1.push_back('{data: d, idx: m + o1_lat});
        end
        I       = d;
        I_valid = v;
        CE      = ce;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b1, 1'b0, -1);
    endtask

    task automatic stream(input logic [WIDTH-1:0] first, input int n, input int o1_lat);
        for (int i = 0; i < n; i++) drive(first + WIDTH'(i), 1'b1, 1'b1, 1'b1, o1_lat);
    endtask

    task automatic check_outputs_clear(input string tag);
        check({tag, "_o0"}, int'(O0), 0);
        check({tag, "_o0_valid"}, int'(O0_valid), 0);
        check({tag, "_o1"}, int'(O1), 0);
        check({tag, "_o1_valid"}, int'(O1_valid), 0);
    endtask

    initial begin
        int base;

        // Reset held two cycles while a valid 0xFF is presented.
        RESET   = 1'b1;
        CE      = 1'b1;
        I       = 8'hFF;
        I_valid = 1'b1;
        tap_sel = '0;
`ifdef TAP_CHAIN_FLUSH_EN
        FLUSH   = 1'b0;
`endif
        @(posedge CLK); #1;
        check_outputs_clear("reset_c1");
        @(posedge CLK); #1;
        check_outputs_clear("reset_c2");
        RESET = 1'b0;
        drive(8'h00, 1'b0, 1'b1, 1'b0, -1);
        check_outputs_clear("reset_after");

        // Latency: tap 1, O0 after 4 edges, O1 after 2+4 edges, back-to-back.
        tap_sel = 3'd1;
        idle(2);
        stream(8'h01, 8, 1 + DEPTH);
        idle(14);

        // Stall: CE low three cycles mid-stream with a valid sample presented.
        stream(8'h11, 4, 1 + DEPTH);
        for (int i = 0; i < 3; i++) drive(8'hAA, 1'b1, 1'b0, 1'b1, 1 + DEPTH);
        stream(8'h15, 4, 1 + DEPTH);
        idle(14);

        // Bubbles: valid, invalid, valid through tap 0 (O1 after 5 edges).
        tap_sel = 3'd0;
        idle(2);
        drive(8'h21, 1'b1, 1'b1, 1'b1, DEPTH);
        drive(8'hEE, 1'b0, 1'b1, 1'b1, DEPTH);
        drive(8'h23, 1'b1, 1'b1, 1'b1, DEPTH);
        idle(12);

        // Clamp: tap_sel 7 behaves as tap 3 (O1 after 8 edges).
        tap_sel = 3'd7;
        idle(2);
        stream(8'h41, 3, 3 + DEPTH);
        idle(16);

        // Tap switch 3 -> 0 before relative edge 6: chain B takes samples
        // 1,2 via stage 4, then 6,7,8 via stage 1; samples 3..5 are skipped.
        tap_sel = 3'd3;
        idle(2);
        base = ce_n;
        q1.push_back('{data: 8'h31, idx: base + 8});
        q1.push_back('{data: 8'h32, idx: base + 9});
        q1.push_back('{data: 8'h36, idx: base + 10});
        q1.push_back('{data: 8'h37, idx: base + 11});
        q1.push_back('{data: 8'h38, idx: base + 12});
        for (int r = 1; r <= 8; r++) begin
            if (r == 6) tap_sel = 3'd0;
            drive(8'h30 + WIDTH'(r), 1'b1, 1'b1, 1'b1, -1);
        end
        idle(16);

        // Reset mid-stream: in-flight samples vanish, outputs clear.
        tap_sel = 3'd0;
        stream(8'h51, 3, DEPTH);
        RESET = 1'b1;
        drive(8'h00, 1'b0, 1'b1, 1'b0, -1);
        q0.delete();
        q1.delete();
        check_outputs_clear("midreset");
        RESET = 1'b0;
        stream(8'h61, 2, DEPTH);
        idle(10);

`ifdef TAP_CHAIN_FLUSH_EN
        // Flush with four samples in flight: only the first reaches O0 before
        // the flush; the flush edge also drops the incoming sample and holds data.
        tap_sel = 3'd1;
        idle(2);
        drive(8'h71, 1'b1, 1'b1, 1'b1, -1);
        for (int i = 0; i < 3; i++) drive(8'h72 + WIDTH'(i), 1'b1, 1'b1, 1'b0, -1);
        FLUSH = 1'b1;
        drive(8'h75, 1'b1, 1'b1, 1'b0, -1);
        FLUSH = 1'b0;
        check("flush_o0_hold", int'(O0), 8'h71);
        check("flush_o0_valid", int'(O0_valid), 0);
        check("flush_o1_valid", int'(O1_valid), 0);
        idle(12);
        stream(8'h81, 2, 1 + DEPTH);
        idle(12);
`endif

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
